// File: rtl/red_pitaya_fads_sorter.sv
// FADS droplet sorter: detects droplets on ADC channel A, measures peak and width,
// gates on both and drives a delayed, timed sort pulse into the ASG trigger.
module red_pitaya_fads_sorter #(
    parameter int DWT = 14,
    parameter int WW  = 16,
    parameter int TW  = 24,
    parameter int CW  = 32
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rst_i,
    input  logic signed [DWT-1:0] adc_a_i,
    output logic                  sort_trig,
    output logic                  drop_active,
    input  logic [31:0]           sys_addr,
    input  logic [31:0]           sys_wdata,
    input  logic [3:0]            sys_sel,
    input  logic                  sys_wen,
    input  logic                  sys_ren,
    output logic [31:0]           sys_rdata,
    output logic                  sys_err,
    output logic                  sys_ack
);

    typedef enum logic [1:0] {D_IDLE, D_MEAS, D_EVAL} d_state_t;
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} s_state_t;

    function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic signed [DWT-1:0] smax(input logic signed [DWT-1:0] a,
                                                  input logic signed [DWT-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // configuration
    logic signed [DWT-1:0] drop_thr, peak_lo, peak_hi;
    logic [WW-1:0]         width_min, width_max;
    logic [TW-1:0]         sort_delay, sort_dur;
    logic                  enable;

    // status
    logic [CW-1:0]         drop_cnt, sort_cnt, miss_cnt;
    logic [WW-1:0]         last_width;
    logic signed [DWT-1:0] last_peak;

    d_state_t              d_state, d_next;
    s_state_t              s_state, s_next;
    logic [WW-1:0]         width;
    logic signed [DWT-1:0] peak;
    logic [TW-1:0]         tcnt, dur_l;
    logic                  above, match, sort_req, cnt_clr;
    logic [19:0]           addr;
    logic [31:0]           rd_mux;
    logic                  unused_bus;

    assign addr       = sys_addr[19:0];
    assign unused_bus = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata};
    assign sys_err    = 1'b0;
    assign above      = adc_a_i > drop_thr;
    assign match      = (peak >= peak_lo) && (peak <= peak_hi) &&
                        (width >= width_min) && (width <= width_max);
    assign cnt_clr    = sys_wen && (addr == 20'h20 || addr == 20'h24 || addr == 20'h28);

    // detector FSM
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) d_state <= D_IDLE;
        else           d_state <= d_next;
    end

    always_comb begin
        d_next      = d_state;
        drop_active = 1'b0;
        sort_req    = 1'b0;
        case (d_state)
            D_IDLE: if (enable && above) d_next = D_MEAS;
            D_MEAS: begin
                drop_active = 1'b1;
                if (!above) d_next = D_EVAL;
            end
            D_EVAL: begin
                sort_req = match;
                d_next   = D_IDLE;
            end
            default: d_next = D_IDLE;
        endcase
    end

    // width/peak are loaded every idle cycle so the first droplet sample always starts fresh
    always_ff @(posedge adc_clk_i) begin
        case (d_state)
            D_IDLE: begin
                width <= WW'(1);
                peak  <= adc_a_i;
            end
            D_MEAS: if (above) begin
                width <= sat_inc(width);
                peak  <= smax(peak, adc_a_i);
            end
            default: ;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            last_width <= '0;
            last_peak  <= '0;
        end else if (d_state == D_EVAL) begin
            last_width <= width;
            last_peak  <= peak;
        end
    end

    // sorter FSM
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) s_state <= S_IDLE;
        else           s_state <= s_next;
    end

    always_comb begin
        s_next    = s_state;
        sort_trig = 1'b0;
        case (s_state)
            S_IDLE: if (sort_req) begin
                if (sort_delay != '0)    s_next = S_DELAY;
                else if (sort_dur != '0) s_next = S_PULSE;
            end
            S_DELAY: if (tcnt == TW'(1)) s_next = (dur_l != '0) ? S_PULSE : S_IDLE;
            S_PULSE: begin
                sort_trig = 1'b1;
                if (tcnt == TW'(1)) s_next = S_IDLE;
            end
            default: s_next = S_IDLE;
        endcase
    end

    // delay and duration are captured at request time; one down-counter serves both phases
    always_ff @(posedge adc_clk_i) begin
        case (s_state)
            S_IDLE: if (sort_req) begin
                dur_l <= sort_dur;
                tcnt  <= (sort_delay != '0) ? sort_delay : sort_dur;
            end
            S_DELAY: tcnt <= (tcnt == TW'(1)) ? dur_l : tcnt - 1'b1;
            S_PULSE: tcnt <= tcnt - 1'b1;
            default: ;
        endcase
    end

    // event counters; a clearing write overrides any same-cycle increment
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i || cnt_clr) begin
            drop_cnt <= '0;
            sort_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (d_state == D_EVAL) drop_cnt <= drop_cnt + 1'b1;
            if (sort_req) begin
                if (s_state == S_IDLE) sort_cnt <= sort_cnt + 1'b1;
                else                   miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            drop_thr   <= DWT'(15);
            peak_lo    <= DWT'(100);
            peak_hi    <= DWT'(1000);
            width_min  <= WW'(1);
            width_max  <= '1;
            sort_delay <= '0;
            sort_dur   <= TW'(100);
            enable     <= 1'b0;
        end else if (sys_wen) begin
            case (addr)
                20'h00: drop_thr   <= sys_wdata[DWT-1:0];
                20'h04: peak_lo    <= sys_wdata[DWT-1:0];
                20'h08: peak_hi    <= sys_wdata[DWT-1:0];
                20'h0C: width_min  <= sys_wdata[WW-1:0];
                20'h10: width_max  <= sys_wdata[WW-1:0];
                20'h14: sort_delay <= sys_wdata[TW-1:0];
                20'h18: sort_dur   <= sys_wdata[TW-1:0];
                20'h1C: enable     <= sys_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            20'h00: rd_mux = 32'(drop_thr);
            20'h04: rd_mux = 32'(peak_lo);
            20'h08: rd_mux = 32'(peak_hi);
            20'h0C: rd_mux = 32'(width_min);
            20'h10: rd_mux = 32'(width_max);
            20'h14: rd_mux = 32'(sort_delay);
            20'h18: rd_mux = 32'(sort_dur);
            20'h1C: rd_mux = {31'd0, enable};
            20'h20: rd_mux = 32'(drop_cnt);
            20'h24: rd_mux = 32'(sort_cnt);
            20'h28: rd_mux = 32'(miss_cnt);
            20'h2C: rd_mux = 32'(last_width);
            20'h30: rd_mux = 32'(last_peak);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            sys_ack   <= sys_wen | sys_ren;
            sys_rdata <= rd_mux;
        end
    end

endmodule
